// File: rtl/msu_stream_ctrl.sv
// MCU-side MSU stream controller: data seek/buffer fill, audio track load,
// and completion strobes back to the register block.
module msu_stream_ctrl #(
  parameter int unsigned HALF_BYTES = 8192,
  localparam int unsigned AW = $clog2(2 * HALF_BYTES)
) (
  input  logic          clkin,
  input  logic          rst_n,
  input  logic [7:0]    status_in,
  input  logic [31:0]   addr_in,
  input  logic [15:0]   track_in,
  input  logic          rd_half,
  output logic          seek_req,
  output logic [31:0]   seek_addr,
  input  logic          seek_ack,
  input  logic [7:0]    byte_data,
  input  logic          byte_valid,
  output logic          byte_ready,
  output logic [AW-1:0] buf_addr,
  output logic [7:0]    buf_data,
  output logic          buf_we_n,
  output logic          track_req,
  output logic [15:0]   track_num,
  input  logic          track_ack,
  input  logic          track_err,
  output logic [5:0]    status_reset_bits,
  output logic [5:0]    status_set_bits,
  output logic          status_reset_we,
  output logic          fill_half
);

  localparam int unsigned CW = $clog2(HALF_BYTES);
  localparam int unsigned SW = 6;
  localparam logic [SW-1:0] DATA_RST = 6'b010000;
  localparam logic [SW-1:0] AUD_RST  = 6'b100000;
  localparam logic [SW-1:0] AUD_ERR  = 6'b001000;

  typedef enum logic [2:0] {
    D_IDLE, D_SEEK, D_FILL0, D_FILL1, D_STREAM, D_REFILL
  } dstate_t;

  typedef enum logic [1:0] {S_IDLE, S_HI, S_GAP} sstate_t;

  dstate_t       dstate, dstate_d;
  sstate_t       sstate, sstate_d;
  logic [1:0]    start_q;
  logic [AW-1:0] wr_ptr, wr_ptr_d;
  logic [CW-1:0] wr_cnt, wr_cnt_d;
  logic          scnt, scnt_d;
  logic          data_pend, data_pend_d;
  logic          aud_pend, aud_pend_d;
  logic [SW-1:0] aud_set, aud_set_d;

  logic          seek_req_d, byte_ready_d, buf_we_n_d, fill_half_d;
  logic [31:0]   seek_addr_d;
  logic [AW-1:0] buf_addr_d;
  logic [7:0]    buf_data_d;
  logic          track_req_d, status_reset_we_d;
  logic [15:0]   track_num_d;
  logic [SW-1:0] status_reset_bits_d, status_set_bits_d;

  logic data_start_c, audio_start_c, accept_c, last_c, data_done_c;
  logic status_unused;

  assign status_unused = ^{status_in[7], status_in[4:0]};
  assign data_start_c  = status_in[5] & ~start_q[0];
  assign audio_start_c = status_in[6] & ~start_q[1];
  assign accept_c      = byte_valid & byte_ready;
  assign last_c        = (wr_cnt == CW'(HALF_BYTES - 1));

  // Data FSM next state: seek, two initial half fills, then refill on half crossings.
  always_comb begin
    dstate_d     = dstate;
    seek_req_d   = seek_req;
    seek_addr_d  = seek_addr;
    byte_ready_d = byte_ready;
    buf_addr_d   = buf_addr;
    buf_data_d   = buf_data;
    buf_we_n_d   = 1'b1;
    wr_ptr_d     = wr_ptr;
    wr_cnt_d     = wr_cnt;
    fill_half_d  = fill_half;
    data_done_c  = 1'b0;

    if (accept_c) begin
      buf_we_n_d = 1'b0;
      buf_addr_d = wr_ptr;
      buf_data_d = byte_data;
      wr_ptr_d   = wr_ptr + AW'(1);
      wr_cnt_d   = wr_cnt + CW'(1);
    end

    if (data_start_c) begin
      // Abort: a byte accepted this cycle is still written, then restart at 0.
      dstate_d     = D_SEEK;
      seek_req_d   = 1'b1;
      seek_addr_d  = addr_in;
      byte_ready_d = 1'b0;
      wr_ptr_d     = '0;
      wr_cnt_d     = '0;
      fill_half_d  = 1'b0;
      if (!accept_c) buf_addr_d = '0;
    end else begin
      unique case (dstate)
        D_IDLE: ;
        D_SEEK: begin
          buf_addr_d = '0;
          if (seek_ack) begin
            seek_req_d   = 1'b0;
            byte_ready_d = 1'b1;
            dstate_d     = D_FILL0;
          end
        end
        D_FILL0: begin
          if (accept_c && last_c) begin
            fill_half_d = 1'b1;
            data_done_c = 1'b1;
            dstate_d    = D_FILL1;
          end
        end
        D_FILL1, D_REFILL: begin
          if (accept_c && last_c) begin
            byte_ready_d = 1'b0;
            dstate_d     = D_STREAM;
          end
        end
        D_STREAM: begin
          // fill_half names the half last written; refill the other once the SNES enters it.
          if (rd_half == fill_half) begin
            fill_half_d  = ~rd_half;
            wr_ptr_d     = {~rd_half, CW'(0)};
            wr_cnt_d     = '0;
            byte_ready_d = 1'b1;
            dstate_d     = D_REFILL;
          end
        end
        default: dstate_d = D_IDLE;
      endcase
    end
  end

  // Data side registers.
  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      dstate     <= D_IDLE;
      start_q    <= '0;
      seek_req   <= 1'b0;
      seek_addr  <= '0;
      byte_ready <= 1'b0;
      buf_addr   <= '0;
      buf_data   <= '0;
      buf_we_n   <= 1'b1;
      wr_ptr     <= '0;
      wr_cnt     <= '0;
      fill_half  <= 1'b0;
    end else begin
      dstate     <= dstate_d;
      start_q    <= status_in[6:5];
      seek_req   <= seek_req_d;
      seek_addr  <= seek_addr_d;
      byte_ready <= byte_ready_d;
      buf_addr   <= buf_addr_d;
      buf_data   <= buf_data_d;
      buf_we_n   <= buf_we_n_d;
      wr_ptr     <= wr_ptr_d;
      wr_cnt     <= wr_cnt_d;
      fill_half  <= fill_half_d;
    end
  end

  // Audio request handling and strobe sequencer (2 cycles high, then at least 2 low).
  always_comb begin
    sstate_d            = sstate;
    scnt_d              = scnt;
    status_reset_we_d   = status_reset_we;
    status_reset_bits_d = status_reset_bits;
    status_set_bits_d   = status_set_bits;
    data_pend_d         = data_pend;
    aud_pend_d          = aud_pend;
    aud_set_d           = aud_set;
    track_req_d         = track_req;
    track_num_d         = track_num;

    unique case (sstate)
      S_IDLE: begin
        if (data_pend) begin
          sstate_d            = S_HI;
          status_reset_we_d   = 1'b1;
          status_reset_bits_d = DATA_RST;
          status_set_bits_d   = '0;
          data_pend_d         = 1'b0;
        end else if (aud_pend) begin
          sstate_d            = S_HI;
          status_reset_we_d   = 1'b1;
          status_reset_bits_d = AUD_RST;
          status_set_bits_d   = aud_set;
          aud_pend_d          = 1'b0;
        end
      end
      S_HI: begin
        if (scnt) begin
          sstate_d            = S_GAP;
          scnt_d              = 1'b0;
          status_reset_we_d   = 1'b0;
          status_reset_bits_d = '0;
          status_set_bits_d   = '0;
        end else begin
          scnt_d = 1'b1;
        end
      end
      S_GAP: begin
        if (scnt) begin
          sstate_d = S_IDLE;
          scnt_d   = 1'b0;
        end else begin
          scnt_d = 1'b1;
        end
      end
      default: sstate_d = S_IDLE;
    endcase

    if (data_done_c)  data_pend_d = 1'b1;
    if (data_start_c) data_pend_d = 1'b0;

    if (track_req && track_ack) begin
      track_req_d = 1'b0;
      aud_pend_d  = 1'b1;
      aud_set_d   = track_err ? AUD_ERR : '0;
    end
    if (audio_start_c) begin
      track_req_d = 1'b1;
      track_num_d = track_in;
    end
  end

  // Audio and strobe registers.
  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      sstate            <= S_IDLE;
      scnt              <= 1'b0;
      status_reset_we   <= 1'b0;
      status_reset_bits <= '0;
      status_set_bits   <= '0;
      data_pend         <= 1'b0;
      aud_pend          <= 1'b0;
      aud_set           <= '0;
      track_req         <= 1'b0;
      track_num         <= '0;
    end else begin
      sstate            <= sstate_d;
      scnt              <= scnt_d;
      status_reset_we   <= status_reset_we_d;
      status_reset_bits <= status_reset_bits_d;
      status_set_bits   <= status_set_bits_d;
      data_pend         <= data_pend_d;
      aud_pend          <= aud_pend_d;
      aud_set           <= aud_set_d;
      track_req         <= track_req_d;
      track_num         <= track_num_d;
    end
  end

endmodule

// File: tb/tb_msu_stream_ctrl.sv
// Scoreboard bench for msu_stream_ctrl: expected writes, strobes and seeks are
// queued by the stimulus and consumed by an independent monitor.
module tb_msu_stream_ctrl;

  logic        clkin = 1'b0;
  logic        rst_n;
  logic [7:0]  status_in;
  logic [31:0] addr_in;
  logic [15:0] track_in;
  logic        rd_half;
  logic        seek_req;
  logic [31:0] seek_addr;
  logic        seek_ack;
  logic [7:0]  byte_data;
  logic        byte_valid;
  logic        byte_ready;
  logic [13:0] buf_addr;
  logic [7:0]  buf_data;
  logic        buf_we_n;
  logic        track_req;
  logic [15:0] track_num;
  logic        track_ack;
  logic        track_err;
  logic [5:0]  status_reset_bits;
  logic [5:0]  status_set_bits;
  logic        status_reset_we;
  logic        fill_half;

  msu_stream_ctrl dut (
    .clkin(clkin), .rst_n(rst_n), .status_in(status_in), .addr_in(addr_in),
    .track_in(track_in), .rd_half(rd_half), .seek_req(seek_req), .seek_addr(seek_addr),
    .seek_ack(seek_ack), .byte_data(byte_data), .byte_valid(byte_valid),
    .byte_ready(byte_ready), .buf_addr(buf_addr), .buf_data(buf_data),
    .buf_we_n(buf_we_n), .track_req(track_req), .track_num(track_num),
    .track_ack(track_ack), .track_err(track_err), .status_reset_bits(status_reset_bits),
    .status_set_bits(status_set_bits), .status_reset_we(status_reset_we),
    .fill_half(fill_half)
  );

  always #5 clkin = ~clkin;

  int tests = 0;
  int fails = 0;

  logic [21:0] wq[$];   // {addr, data}
  logic [11:0] sq[$];   // {reset_bits, set_bits}
  logic [31:0] kq[$];   // seek addresses

  int  wr_seen = 0;
  int  last_snap = 0;
  int  hi_len = 0;
  int  gap_len = 0;
  bit  seen_strobe = 0;
  logic we_prev = 1'b0;
  logic sr_prev = 1'b0;
  logic [11:0] cur_bits = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name, input int act);
    tests++;
    fails++;
    $display("FAIL %s: got %0d, nothing expected", name, act);
  endtask

  function automatic logic [7:0] pat(input int base, input int i);
    return 8'((base + i) * 5 + (i >> 8));
  endfunction

  // Monitor: consumes expected writes, strobes and seeks as the DUT presents them.
  always @(negedge clkin) begin
    if (!rst_n) begin
      we_prev = 1'b0;
      sr_prev = 1'b0;
      hi_len  = 0;
      gap_len = 0;
    end else begin
      if (!buf_we_n) begin
        wr_seen++;
        if (wq.size() == 0) fail_now("unexpected_write", int'(buf_addr));
        else begin
          logic [21:0] e;
          e = wq.pop_front();
          check("write_addr", 32'(buf_addr), 32'(e[21:8]));
          check("write_data", 32'(buf_data), 32'(e[7:0]));
        end
      end
      if (status_reset_we && !we_prev) begin
        last_snap = wr_seen;
        if (seen_strobe) begin
          tests++;
          if (gap_len < 2) begin
            fails++;
            $display("FAIL strobe_gap: got %0d idle cycles, need >=2", gap_len);
          end
        end
        cur_bits = {status_reset_bits, status_set_bits};
        hi_len = 1;
        if (sq.size() == 0) fail_now("unexpected_strobe", int'(cur_bits));
        else check("strobe_bits", 32'(cur_bits), 32'(sq.pop_front()));
      end else if (status_reset_we) begin
        hi_len++;
        check("strobe_stable", 32'({status_reset_bits, status_set_bits}), 32'(cur_bits));
      end else if (we_prev) begin
        check("strobe_width", 32'(hi_len), 32'd2);
        check("strobe_bits_cleared", 32'({status_reset_bits, status_set_bits}), 32'd0);
        seen_strobe = 1;
        gap_len = 1;
      end else begin
        gap_len++;
      end
      we_prev = status_reset_we;
      if (seek_req && !sr_prev) begin
        if (kq.size() == 0) fail_now("unexpected_seek", int'(seek_addr));
        else check("seek_addr", seek_addr, kq.pop_front());
      end
      sr_prev = seek_req;
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clkin);
  endtask

  task automatic pulse_status(input logic [7:0] v);
    @(negedge clkin);
    status_in = v;
    @(negedge clkin);
    status_in = 8'h00;
  endtask

  task automatic wait_seek_and_ack(input int delay);
    int n = 0;
    while (!seek_req && n < 20) begin
      @(negedge clkin);
      n++;
    end
    check("seek_req_seen", 32'(seek_req), 32'd1);
    cycles(delay);
    seek_ack = 1'b1;
    @(negedge clkin);
    seek_ack = 1'b0;
  endtask

  // Offer n bytes addressed from base; toggle inserts an idle cycle between offers.
  task automatic send_bytes(input int base, input int n, input bit toggle, input bit ack_last);
    int i = 0;
    int guard = 0;
    bit phase = 1'b0;
    while (i < n && guard < 4 * n + 100) begin
      @(negedge clkin);
      guard++;
      track_ack = 1'b0;
      phase = ~phase;
      if (toggle && !phase) begin
        byte_valid = 1'b0;
      end else begin
        byte_valid = 1'b1;
        byte_data  = pat(base, i);
        if (byte_ready) begin
          wq.push_back({14'(base + i), pat(base, i)});
          if (ack_last && i == n - 1) begin
            track_ack = 1'b1;
            track_err = 1'b0;
          end
          i++;
        end
      end
    end
    if (i < n) fail_now("byte_accept_timeout", i);
    @(negedge clkin);
    byte_valid = 1'b0;
    track_ack  = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; status_in = 8'h00; addr_in = '0; track_in = '0; rd_half = 1'b0;
    seek_ack = 1'b0; byte_data = '0; byte_valid = 1'b0; track_ack = 1'b0; track_err = 1'b0;
    cycles(3);
    check("rst_seek_req", 32'(seek_req), 32'd0);
    check("rst_seek_addr", seek_addr, 32'd0);
    check("rst_byte_ready", 32'(byte_ready), 32'd0);
    check("rst_buf_addr", 32'(buf_addr), 32'd0);
    check("rst_buf_we_n", 32'(buf_we_n), 32'd1);
    check("rst_track_req", 32'(track_req), 32'd0);
    check("rst_strobe", 32'({status_reset_we, status_reset_bits, status_set_bits}), 32'd0);
    check("rst_fill_half", 32'(fill_half), 32'd0);
    rst_n = 1'b1;
    cycles(2);

    // Full initial fill: half 0, data strobe, half 1.
    addr_in = 32'h0001_2345;
    kq.push_back(32'h0001_2345);
    sq.push_back({6'h10, 6'h00});
    pulse_status(8'h20);
    wait_seek_and_ack(3);
    send_bytes(0, 16384, 1'b0, 1'b0);
    cycles(4);
    check("fill_snap_writes_at_strobe", 32'(last_snap), 32'd8193);
    check("fill_done_ready", 32'(byte_ready), 32'd0);
    check("fill_done_half", 32'(fill_half), 32'd1);
    check("fill_writes_left", 32'(wq.size()), 32'd0);
    cycles(6);

    // SNES moves into half 1: refill half 0 with a stuttering source.
    rd_half = 1'b1;
    cycles(3);
    check("refill0_half", 32'(fill_half), 32'd0);
    send_bytes(0, 8192, 1'b1, 1'b0);
    cycles(3);
    check("refill0_ready", 32'(byte_ready), 32'd0);
    check("refill0_left", 32'(wq.size()), 32'd0);

    // SNES back into half 0: refill half 1.
    rd_half = 1'b0;
    cycles(3);
    check("refill1_half", 32'(fill_half), 32'd1);
    send_bytes(8192, 8192, 1'b0, 1'b0);
    cycles(3);
    check("refill1_ready", 32'(byte_ready), 32'd0);
    check("refill1_left", 32'(wq.size()), 32'd0);

    // Abort after 100 bytes of FILL0: new seek, no strobe.
    addr_in = 32'h0000_1000;
    kq.push_back(32'h0000_1000);
    pulse_status(8'h20);
    wait_seek_and_ack(1);
    send_bytes(0, 100, 1'b0, 1'b0);
    addr_in = 32'h00AB_C000;
    kq.push_back(32'h00AB_C000);
    pulse_status(8'h20);
    cycles(2);
    check("abort_seek_req", 32'(seek_req), 32'd1);
    check("abort_buf_addr", 32'(buf_addr), 32'd0);
    check("abort_byte_ready", 32'(byte_ready), 32'd0);
    check("abort_fill_half", 32'(fill_half), 32'd0);

    // Data completion and track_ack in the same cycle: data strobe then audio strobe.
    track_in = 16'h0077;
    pulse_status(8'h40);
    cycles(1);
    check("aud_req_a", 32'(track_req), 32'd1);
    check("aud_num_a", 32'(track_num), 32'h0077);
    sq.push_back({6'h10, 6'h00});
    sq.push_back({6'h20, 6'h00});
    wait_seek_and_ack(2);
    send_bytes(0, 8192, 1'b0, 1'b1);
    cycles(16);
    check("aud_req_a_done", 32'(track_req), 32'd0);
    check("both_strobes_left", 32'(sq.size()), 32'd0);

    // Audio start, re-start while pending, then error completion.
    track_in = 16'h0041;
    pulse_status(8'h40);
    track_in = 16'h0042;
    pulse_status(8'h40);
    cycles(1);
    check("aud_req_b", 32'(track_req), 32'd1);
    check("aud_relatch", 32'(track_num), 32'h0042);
    sq.push_back({6'h20, 6'h08});
    @(negedge clkin);
    track_ack = 1'b1;
    track_err = 1'b1;
    @(negedge clkin);
    track_ack = 1'b0;
    track_err = 1'b0;
    check("aud_req_b_done", 32'(track_req), 32'd0);
    cycles(10);
    check("err_strobe_left", 32'(sq.size()), 32'd0);

    // Asynchronous reset in the middle of a seek.
    addr_in = 32'h0BAD_F00D;
    kq.push_back(32'h0BAD_F00D);
    pulse_status(8'h20);
    cycles(1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_seek_req", 32'(seek_req), 32'd0);
    check("arst_seek_addr", seek_addr, 32'd0);
    check("arst_track_num", 32'(track_num), 32'd0);
    check("arst_buf_we_n", 32'(buf_we_n), 32'd1);
    check("arst_strobe", 32'(status_reset_we), 32'd0);
    cycles(2);
    rst_n = 1'b1;
    cycles(10);
    check("final_writes_left", 32'(wq.size()), 32'd0);
    check("final_strobes_left", 32'(sq.size()), 32'd0);
    check("final_seeks_left", 32'(kq.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
